// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bundle between the datapath and the data-memory responder
//
// Groups the request channel (req_*), the response channel (rsp_*) and busy.
//   master : requester side (drives req_valid/we/addr/wdata/funct3, rsp_ready)
//   slave  : responder side (drives req_ready, rsp_valid/rdata/err, busy)
interface dmem_responder_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [2:0]        req_funct3;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder with RISC-V load/store sizing
//
// Accepts one request at a time, waits WAIT_CYCLES wait states, performs a
// byte/half/word access (funct3 sizing and sign handling), then holds the
// response until the requester takes it.
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : dmem_responder_if.slave (req_*, rsp_*, busy)
// Optional macro DMEM_MISALIGN_CHECK_EN: reject misaligned half/word accesses
// instead of silently aligning them.
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [2:0]        lat_f3;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    logic [31:0] mem [0:(2**(ADDR_W-2))-1];

    logic [31:0] word_rd;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] store_word;
    logic        legal;

    assign word_rd  = mem[lat_addr[ADDR_W-1:2]];
    assign half_sel = lat_addr[1] ? word_rd[31:16] : word_rd[15:0];

    always_comb begin
        byte_sel = word_rd[7:0];
        case (lat_addr[1:0])
            2'd0: byte_sel = word_rd[7:0];
            2'd1: byte_sel = word_rd[15:8];
            2'd2: byte_sel = word_rd[23:16];
            2'd3: byte_sel = word_rd[31:24];
            default: byte_sel = word_rd[7:0];
        endcase
    end

    // Unsigned size encodings (100/101) exist only for loads.
    always_comb begin
        legal = 1'b0;
        case (lat_f3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !lat_we;
            default:                legal = 1'b0;
        endcase
`ifdef DMEM_MISALIGN_CHECK_EN
        if (lat_f3[1:0] == 2'b01 && lat_addr[0])
            legal = 1'b0;
        if (lat_f3[1:0] == 2'b10 && lat_addr[1:0] != 2'b00)
            legal = 1'b0;
`endif
    end

    always_comb begin
        load_data = 32'd0;
        case (lat_f3)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'd0, half_sel};
            3'b010:  load_data = word_rd;
            default: load_data = 32'd0;
        endcase
    end

    // Read-modify-write merge: only the addressed lane(s) take new data.
    always_comb begin
        store_word = word_rd;
        case (lat_f3)
            3'b000: begin
                case (lat_addr[1:0])
                    2'd0: store_word[7:0]   = lat_wdata[7:0];
                    2'd1: store_word[15:8]  = lat_wdata[7:0];
                    2'd2: store_word[23:16] = lat_wdata[7:0];
                    2'd3: store_word[31:24] = lat_wdata[7:0];
                    default: store_word = word_rd;
                endcase
            end
            3'b001: begin
                if (lat_addr[1])
                    store_word[31:16] = lat_wdata[15:0];
                else
                    store_word[15:0] = lat_wdata[15:0];
            end
            3'b010:  store_word = lat_wdata;
            default: store_word = word_rd;
        endcase
    end

    // Storage has no reset; only the ACCESS cycle of a legal store writes it.
    always_ff @(posedge clk) begin
        if (state == ST_ACCESS && lat_we && legal)
            mem[lat_addr[ADDR_W-1:2]] <= store_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= 32'd0;
            lat_f3      <= 3'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        lat_we    <= bus.req_we;
                        lat_addr  <= bus.req_addr;
                        lat_wdata <= bus.req_wdata;
                        lat_f3    <= bus.req_funct3;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_ACCESS;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0)
                        state <= ST_ACCESS;
                    else
                        cnt <= cnt - 4'd1;
                end
                ST_ACCESS: begin
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= (legal && !lat_we) ? load_data : 32'd0;
                    rsp_err_q   <= !legal;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
